// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX serializer between NUM_REQ byte-stream requesters.
//   The transmitter is granted for a whole packet (bytes up to and including
//   one flagged req_last). The chosen byte is registered toward the
//   serializer, a guard gap follows every packet, and a watchdog revokes a
//   grant whose owner stalls mid-packet.
//
//   Build option: define UART_TX_ARB_FIXED_PRIO_EN to make arbitration pick
//   the lowest-index valid requester. Left undefined (default), arbitration
//   is round-robin starting after the most recent grantee.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,      // 2..8
    parameter int GUARD_CYCLES = 234,    // idle clocks after each packet
    parameter int TIMEOUT      = 65535,  // stall limit mid-packet, >= 1
    parameter int ID_W         = 2       // >= ceil(log2(NUM_REQ))
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);

    // Guard counter only has to reach GUARD_CYCLES-1.
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    // Watchdog fires on the TIMEOUT-th consecutive clock without an accept.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_XFER,
        S_GUARD
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       wd_cnt_q, wd_cnt_d;
    logic [GW-1:0]     guard_cnt_q, guard_cnt_d;

    // Grantee lane selection.
    logic              lane_ready;
    logic              sel_valid;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic              accept;

    // Arbitration result.
    logic              arb_found;
    logic [ID_W-1:0]   arb_id;

    // Route the grantee's lane to the holding register and raise its ready.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        lane_ready = (state_q == S_XFER) && (!tx_valid_q || tx_ready);
        req_ready  = '0;
        sel_valid  = 1'b0;
        sel_data   = 8'h00;
        sel_last   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                req_ready[i] = lane_ready;
                sel_valid    = req_valid[i];
                sel_data     = req_data[8*i +: 8];
                sel_last     = req_last[i];
            end
        end
    end

    assign accept = sel_valid && lane_ready;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index valid requester wins; pointer unused.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        // Walking downward lets the lowest valid index overwrite last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(i);
            end
        end
    end
`else
    // Round-robin: the order is ptr+1 .. NUM_REQ-1, then 0 .. ptr.
    logic              hi_found, lo_found;
    logic [ID_W-1:0]   hi_id, lo_id;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        // Two buckets around the pointer; within each bucket the lowest index
        // wins because the downward walk overwrites it last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = ID_W'(i);
                end
            end
        end
        arb_found = hi_found || lo_found;
        arb_id    = hi_found ? hi_id : lo_id;
    end
`endif

    // Next-state logic for the packet FSM, holding register, and counters.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        timeout_err_d = 1'b0;
        wd_cnt_d      = wd_cnt_q;
        guard_cnt_d   = guard_cnt_q;

        // Holding register: a new accept wins over a drain, so a simultaneous
        // drain plus accept keeps tx_valid high with the new byte.
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d = S_ARB;
                end
            end

            S_ARB: begin
                // Requests may be withdrawn before grant; then fall back idle.
                if (arb_found) begin
                    grant_id_d    = arb_id;
                    grant_valid_d = 1'b1;
                    wd_cnt_d      = '0;
                    state_d       = S_XFER;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_XFER: begin
                if (accept) begin
                    wd_cnt_d = '0;
                    if (sel_last) begin
                        grant_valid_d = 1'b0;
                        ptr_d         = grant_id_q;
                        guard_cnt_d   = '0;
                        state_d       = S_GUARD;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    // Stalled owner: revoke the grant. Any byte already in the
                    // holding register still drains during the guard.
                    grant_valid_d = 1'b0;
                    timeout_err_d = 1'b1;
                    ptr_d         = grant_id_q;
                    wd_cnt_d      = '0;
                    guard_cnt_d   = '0;
                    state_d       = S_GUARD;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end

            S_GUARD: begin
                // The gap is measured from the last byte leaving, so the
                // counter stays parked at zero while a byte is still pending.
                if (tx_valid_q) begin
                    guard_cnt_d = '0;
                end else if (GUARD_CYCLES == 0 || guard_cnt_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant and pending byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= ID_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= '0;
            guard_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: queue-based requesters, scoreboard of
// expected tx bytes and grants, plus watchdog and reset checks.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GUARD   = 234;
    localparam int TMO     = 16;
    localparam int ID_W    = 2;
    localparam int GAP     = GUARD + 2;   // last byte out (or revoke) to next grant

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready = 1'b1;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GUARD_CYCLES (GUARD),
        .TIMEOUT      (TMO),
        .ID_W         (ID_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_to     = 0;

    typedef struct {
        int id;
        int gap;   // 0 = spacing not checked
    } gexp_t;

    gexp_t      exp_grant[$];
    logic [7:0] exp_tx[$];
    logic [8:0] src_q[NUM_REQ][$];     // {last, data} per requester
    logic [NUM_REQ-1:0] acc_s = '0;

    int last_acc   = 0;
    int last_leave = 0;
    int prev_leave = 0;
    int ref_cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) acc_s <= req_valid & req_ready;

    // Requester model: present queue head, pop it once accepted.
    initial begin : source
        logic [8:0] item;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    item = src_q[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = item[7:0];
                    req_last[i]        = item[8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: sample on the falling edge, compare against the scoreboard.
    initial begin : monitor
        gexp_t g;
        logic  gv_prev;
        logic  to_prev;
        gv_prev = 1'b0;
        to_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                gv_prev = 1'b0;
                to_prev = 1'b0;
                continue;
            end
            if (|(req_valid & req_ready)) last_acc = cyc + 1;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
                else                   check("tx_extra", tx_data, 32'hFFFF_FFFF);
                prev_leave = last_leave;
                last_leave = cyc + 1;
                ref_cyc    = cyc + 1;
            end
            if (grant_valid && !gv_prev) begin
                if (exp_grant.size() > 0) begin
                    g = exp_grant.pop_front();
                    check("grant_id", grant_id, g.id);
                    if (g.gap > 0) check("grant_gap", cyc - ref_cyc, g.gap);
                end else begin
                    check("grant_extra", grant_id, 32'hFFFF_FFFF);
                end
            end
            if (timeout_err) begin
                n_to++;
                check("to_delay", cyc - last_acc, TMO);
                check("to_width", to_prev, 0);
                check("to_grant_drop", grant_valid, 0);
                check("to_grant_was_high", gv_prev, 1);
                ref_cyc = cyc;
            end
            gv_prev = grant_valid;
            to_prev = timeout_err;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic exp_g(input int id, input int gap);
        gexp_t g;
        g.id  = id;
        g.gap = gap;
        exp_grant.push_back(g);
    endtask

    task automatic wait_sb(input int budget, input string tag);
        int n = 0;
        while ((exp_tx.size() > 0 || exp_grant.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, exp_tx.size() + exp_grant.size(), 0);
        repeat (GUARD + 6) step();
    endtask

    task automatic wait_grants_left(input int left, input int budget, input string tag);
        int n = 0;
        while (exp_grant.size() > left && n < budget) begin
            step();
            n++;
        end
        check(tag, exp_grant.size() > left, 0);
    endtask

    task automatic wait_tx_left(input int left, input int budget, input string tag);
        int n = 0;
        while (exp_tx.size() > left && n < budget) begin
            step();
            n++;
        end
        check(tag, exp_tx.size() > left, 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tx_valid"},    tx_valid,    0);
        check({pfx, "_tx_data"},     tx_data,     0);
        check({pfx, "_grant_valid"}, grant_valid, 0);
        check({pfx, "_grant_id"},    grant_id,    0);
        check({pfx, "_timeout_err"}, timeout_err, 0);
        check({pfx, "_req_ready"},   req_ready,   0);
    endtask

    initial begin : global_limit
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [7:0] held;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step();

        // Round-robin fairness from reset: pointer starts at NUM_REQ-1.
        for (int i = 0; i < NUM_REQ; i++) push_src(i, 8'h10 + 8'(i), 1'b1);
        push_src(0, 8'h20, 1'b1);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_g(0, 0); exp_g(0, GAP); exp_g(1, GAP); exp_g(2, GAP); exp_g(3, GAP);
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h20); exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h13);
`else
        exp_g(0, 0); exp_g(1, GAP); exp_g(2, GAP); exp_g(3, GAP); exp_g(0, GAP);
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h11); exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h13); exp_tx.push_back(8'h20);
`endif
        wait_sb(2000, "rr_done");

        // "Hi" from requester 2, back-to-back; requester 0 queued behind it.
        push_src(2, 8'h48, 1'b0);
        push_src(2, 8'h69, 1'b1);
        exp_tx.push_back(8'h48);
        exp_tx.push_back(8'h69);
        exp_g(2, 0);
        wait_grants_left(0, 50, "hi_grant_wait");
        push_src(0, 8'hA0, 1'b1);
        exp_tx.push_back(8'hA0);
        exp_g(0, GAP);
        wait_tx_left(1, 50, "hi_tx_wait");
        check("hi_back_to_back", last_leave - prev_leave, 1);
        wait_sb(600, "hi_done");

        // Backpressure mid-packet: 0x01..0x05 from requester 0.
        for (int b = 1; b <= 5; b++) begin
            push_src(0, 8'(b), (b == 5));
            exp_tx.push_back(8'(b));
        end
        exp_g(0, 0);
        wait_tx_left(3, 300, "bp_tx_wait");
        tx_ready = 1'b0;
        held = exp_tx[0];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_tx_data", tx_data, held);
            check("bp_tx_valid", tx_valid, 1);
            check("bp_req_ready", req_ready, 0);
        end
        step();
        tx_ready = 1'b1;
        wait_sb(300, "bp_done");

        // Watchdog: requester 1 stalls after one byte; requester 3 follows.
        push_src(1, 8'h77, 1'b0);
        exp_tx.push_back(8'h77);
        exp_g(1, 0);
        wait_grants_left(0, 50, "wd_grant_wait");
        push_src(3, 8'h33, 1'b1);
        exp_tx.push_back(8'h33);
        exp_g(3, GAP);
        wait_sb(600, "wd_done");
        check("to_count", n_to, 1);

        // Leave the pointer at 0 so a lost pointer reset would favour 1.
        push_src(0, 8'hB0, 1'b1);
        exp_tx.push_back(8'hB0);
        exp_g(0, 0);
        wait_sb(300, "pre_rst_done");

        // Reset in the middle of a 5-byte packet from requester 2.
        for (int b = 0; b < 5; b++) begin
            push_src(2, 8'h51 + 8'(b), (b == 4));
            exp_tx.push_back(8'h51 + 8'(b));
        end
        exp_g(2, 0);
        wait_tx_left(3, 300, "mid_tx_wait");
        check("mid_byte3_held", tx_data, 8'h53);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_tx.delete();
        exp_grant.delete();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        step();
        reset_n = 1'b1;
        step();
        push_src(1, 8'hC1, 1'b1);
        push_src(0, 8'hC0, 1'b1);
        exp_g(0, 0);
        exp_g(1, GAP);
        exp_tx.push_back(8'hC0);
        exp_tx.push_back(8'hC1);
        wait_sb(800, "post_rst_done");
        check("to_count_final", n_to, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit serializer between several byte-stream requesters, such as the button-triggered message sender and the RX echo/status reporter. It grants the transmitter to one requester per packet, where a packet is a run of bytes ending with a `last` flag. It registers the chosen byte toward the serializer and inserts a guard gap between packets. A watchdog reclaims the transmitter from a requester that stalls mid-packet.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `GUARD_CYCLES`, default 234: idle clocks inserted after each packet (one bit time at 27 MHz / 115200).
- `TIMEOUT`, default 65535: maximum clocks without an accepted byte mid-packet before the grant is revoked. Counter is 16 bits wide.
- `ID_W`, default 2: width of `grant_id`. Must satisfy `ID_W` ≥ ceil(log2(`NUM_REQ`)).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8·`NUM_REQ`  byte lanes, one per requester.
- `req_last`  in  `NUM_REQ`  the presented byte is the final byte of its packet.
- `req_ready`  out  `NUM_REQ`  byte accept strobe, per requester.
- `tx_valid`  out  1  registered byte available to the serializer.
- `tx_data`  out  8  registered byte.
- `tx_ready`  in  1  serializer takes the byte this cycle when `tx_valid` is also high.
- `grant_valid`  out  1  high while a requester holds the transmitter.
- `grant_id`  out  `ID_W`  index of the current or most recent grantee.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- The state machine has four states: IDLE, ARB, XFER, GUARD.
- **IDLE:** if any `req_valid` is high, go to ARB.
- **ARB:** select the winner among the current `req_valid` bits and register it into `grant_id`. Set `grant_valid`=1 and go to XFER. If no request remains, return to IDLE with no grant.
- **XFER:**
  - `req_ready[grant_id]` = (`tx_valid`==0 || `tx_ready`). All other `req_ready` bits are 0.
  - On accept (`req_valid`·`req_ready`), load `tx_data` with the byte and set `tx_valid`=1.
  - When `tx_valid`·`tx_ready` and no new byte is accepted, clear `tx_valid`.
  - An accept with `req_last`=1 clears `grant_valid`, updates the round-robin pointer to `grant_id`, and goes to GUARD.
- **Watchdog:** counts in XFER while no byte is accepted and resets to 0 on every accept. When it reaches `TIMEOUT`:
  - clear `grant_valid` and pulse `timeout_err`;
  - update the pointer as for a normal packet end;
  - go to GUARD. A byte already in `tx_data` is still delivered.
- **GUARD:** the counter starts at 0 once `tx_valid`==0 and counts up. On reaching `GUARD_CYCLES`-1, go to IDLE. With `GUARD_CYCLES`=0, go to IDLE on the first cycle that `tx_valid`==0.
- **Round-robin:** search starts at pointer+1 and wraps modulo `NUM_REQ`. After reset the pointer is `NUM_REQ`-1, so requester 0 has first priority.
- **Flow rules:**
  - Requesters must hold `req_valid`/`req_data`/`req_last` stable until accepted.
  - Withdrawing a request before it is granted is legal.
  - Withdrawing during XFER is treated as a stall and is covered by the watchdog.

## Timing
- Reset values: `req_ready`=0, `tx_valid`=0, `tx_data`=0, `grant_valid`=0, `grant_id`=0, `timeout_err`=0, state=IDLE, pointer=`NUM_REQ`-1.
- Assertion of `reset_n` mid-packet drops the grant and the pending byte immediately. Nothing resumes after release.
- Latency from `req_valid` rising in IDLE:
  - `grant_valid` high 2 cycles later;
  - first `req_ready` in that same cycle;
  - `tx_valid` the cycle after the accept.
- Sustained throughput is one byte per clock while `tx_ready` is held high.
- A simultaneous `tx_ready` drain and new accept keeps `tx_valid`=1 and loads the new data.
- `timeout_err` is high for exactly one clock, the same clock in which `grant_valid` falls.
- Minimum spacing from the last byte leaving (`tx_valid`·`tx_ready`) to the next grant is `GUARD_CYCLES`+2 clocks.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`
  - **Defined:** ARB always picks the lowest-index valid requester, and the pointer is ignored.
  - **Undefined (default):** round-robin arbitration as described in Operation.

## Test plan
- **Single packet, back-to-back bytes:** requester 2 sends "Hi" (0x48, 0x69 with `last`), `tx_ready`=1 → `grant_id`=2, `tx_data` 0x48 then 0x69 on consecutive clocks, then 234 idle clocks before any new grant.
- **Round-robin fairness:** all four requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0. With `UART_TX_ARB_FIXED_PRIO_EN` defined → 0,0,0.
- **Backpressure:** `tx_ready` held low for 10 clocks mid-packet → `tx_data` stable, `req_ready`=0, no byte dropped or duplicated, and sequence 0x01..0x05 is delivered intact.
- **Watchdog:** `TIMEOUT`=16; requester 1 sends one byte without `last`, then drops `req_valid` → `timeout_err` pulses 16 clocks after the accept, `grant_valid` falls, and requester 3 is granted after the guard.
- **Reset mid-packet:** `reset_n` pulsed low during byte 3 of 5 → all outputs at reset values in the same cycle, and after release requester 0 wins first.
